hough_peak_finder: RTL

HOUGH_PEAK_FINDER -- requirements
Module: hough_peak_finder

---
 rtl/hough_peak_finder_if.sv | 43 ++++
 rtl/hough_peak_finder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hough_peak_finder_if.sv
// -----------------------------------------------------------------------------
// hough_peak_finder_if
// Bundles the control handshake, the accumulator memory ports and the result
// outputs of hough_peak_finder.
//   slave  : the peak finder side (drives done/busy/acc_* addresses/results)
//   master : the controller/memory side (drives start, clear_en, threshold,
//            and returns acc_rdata one cycle after acc_raddr)
// Signals:
//   start, clear_en, threshold   scan request and per-scan settings
//   done, busy                   scan status
//   acc_raddr / acc_rdata        accumulator read port {angle_idx[5:0], r_idx[10:0]}
//   acc_we / acc_waddr / acc_wdata  accumulator clear-on-read write port
//   peak_r, peak_angle, peak_votes, peak_valid, over_count  scan results
// -----------------------------------------------------------------------------
interface hough_peak_finder_if;
  logic               start;
  logic               done;
  logic               busy;
  logic               clear_en;
  logic [15:0]        threshold;
  logic [16:0]        acc_raddr;
  logic [15:0]        acc_rdata;
  logic               acc_we;
  logic [16:0]        acc_waddr;
  logic [15:0]        acc_wdata;
  logic signed [12:0] peak_r;
  logic [7:0]         peak_angle;
  logic [15:0]        peak_votes;
  logic               peak_valid;
  logic [15:0]        over_count;

  modport slave (
    input  start, clear_en, threshold, acc_rdata,
    output done, busy, acc_raddr, acc_we, acc_waddr, acc_wdata,
           peak_r, peak_angle, peak_votes, peak_valid, over_count
  );

  modport master (
    output start, clear_en, threshold, acc_rdata,
    input  done, busy, acc_raddr, acc_we, acc_waddr, acc_wdata,
           peak_r, peak_angle, peak_votes, peak_valid, over_count
  );
endinterface

// File: rtl/hough_peak_finder.sv
// -----------------------------------------------------------------------------
// hough_peak_finder
// Scans a Hough accumulator (N_ANGLES x R_BINS vote counters) one bin per
// cycle, tracks the strongest bin and counts bins at or above a threshold.
// Optionally zeroes every bin as it is read so the accumulator is ready for
// the next frame.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high; clears all state
//   bus    hough_peak_finder_if.slave (handshake, memory ports, results)
// Timing: start accepted at edge 0, address k (1-based) presented in cycle k,
// its data consumed in cycle k+1, done pulses in cycle R_BINS*N_ANGLES+2.
// -----------------------------------------------------------------------------
module hough_peak_finder #(
  parameter int R_BINS     = 1440,
  parameter int R_OFFSET   = 640,
  parameter int N_ANGLES   = 45,
  parameter int ANGLE_STEP = 4
) (
  input  logic                clk,
  input  logic                reset,
  hough_peak_finder_if.slave  bus
);

  localparam logic [10:0] R_LAST = 11'(R_BINS - 1);
  localparam logic [5:0]  A_LAST = 6'(N_ANGLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q;
  logic               busy_q;
  logic               done_q;
  logic [15:0]        thr_q;
  logic               clr_q;

  // Scan position counters (next address to issue)
  logic [10:0]        r_cnt_q;
  logic [5:0]         ang_cnt_q;

  // Stage 0: issued read address and its valid flag
  logic [16:0]        raddr_p0_q;
  logic               vld_p0_q;

  // Stage 1: address copy aligned with acc_rdata
  logic [16:0]        addr_p1_q;
  logic               vld_p1_q;
  logic               we_p1_q;

  // Running best and threshold count
  logic [15:0]        best_votes_q, best_votes_d;
  logic [10:0]        best_r_q,     best_r_d;
  logic [5:0]         best_ang_q,   best_ang_d;
  logic [15:0]        over_q,       over_d;

  // Published results
  logic signed [12:0] peak_r_q;
  logic [7:0]         peak_angle_q;
  logic [15:0]        peak_votes_q;
  logic               peak_valid_q;
  logic [15:0]        over_count_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic signed [12:0] bin_to_r(input logic [10:0] r_idx);
    logic signed [12:0] r_s;
    r_s = signed'({2'b00, r_idx});
    return r_s - signed'(13'(R_OFFSET));
  endfunction

  function automatic logic [7:0] bin_to_angle(input logic [5:0] a_idx);
    logic [13:0] prod;
    prod = 14'(a_idx) * 14'(ANGLE_STEP);
    return prod[7:0];
  endfunction

  // Stage 1 -> best/count update: strictly-greater keeps the earliest bin on ties
  always_comb begin
    best_votes_d = best_votes_q;
    best_r_d     = best_r_q;
    best_ang_d   = best_ang_q;
    over_d       = over_q;
    if (vld_p1_q) begin
      if (bus.acc_rdata > best_votes_q) begin
        best_votes_d = bus.acc_rdata;
        best_r_d     = addr_p1_q[10:0];
        best_ang_d   = addr_p1_q[16:11];
      end
      if (bus.acc_rdata >= thr_q) begin
        over_d = sat_inc(over_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      thr_q        <= '0;
      clr_q        <= 1'b0;
      r_cnt_q      <= '0;
      ang_cnt_q    <= '0;
      raddr_p0_q   <= '0;
      vld_p0_q     <= 1'b0;
      addr_p1_q    <= '0;
      vld_p1_q     <= 1'b0;
      we_p1_q      <= 1'b0;
      best_votes_q <= '0;
      best_r_q     <= '0;
      best_ang_q   <= '0;
      over_q       <= '0;
      peak_r_q     <= '0;
      peak_angle_q <= '0;
      peak_votes_q <= '0;
      peak_valid_q <= 1'b0;
      over_count_q <= '0;
    end else begin
      done_q <= 1'b0;

      // Stage 0 -> stage 1: delayed address doubles as the clear write address
      addr_p1_q <= raddr_p0_q;
      vld_p1_q  <= vld_p0_q;
      we_p1_q   <= vld_p0_q & clr_q;

      case (state_q)
        IDLE: begin
          vld_p0_q <= 1'b0;
          if (bus.start) begin
            state_q      <= SCAN;
            busy_q       <= 1'b1;
            thr_q        <= bus.threshold;
            clr_q        <= bus.clear_en;
            r_cnt_q      <= '0;
            ang_cnt_q    <= '0;
            best_votes_q <= '0;
            best_r_q     <= '0;
            best_ang_q   <= '0;
            over_q       <= '0;
          end
        end

        SCAN: begin
          raddr_p0_q   <= {ang_cnt_q, r_cnt_q};
          vld_p0_q     <= 1'b1;
          best_votes_q <= best_votes_d;
          best_r_q     <= best_r_d;
          best_ang_q   <= best_ang_d;
          over_q       <= over_d;
          if (r_cnt_q == R_LAST) begin
            r_cnt_q <= '0;
            if (ang_cnt_q == A_LAST) begin
              state_q <= DRAIN;
            end else begin
              ang_cnt_q <= ang_cnt_q + 6'd1;
            end
          end else begin
            r_cnt_q <= r_cnt_q + 11'd1;
          end
        end

        DRAIN: begin
          vld_p0_q     <= 1'b0;
          best_votes_q <= best_votes_d;
          best_r_q     <= best_r_d;
          best_ang_q   <= best_ang_d;
          over_q       <= over_d;
          // With stage 0 empty, the bin now in stage 1 is the last one; fold
          // it straight into the published results.
          if (!vld_p0_q) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            peak_r_q     <= bin_to_r(best_r_d);
            peak_angle_q <= bin_to_angle(best_ang_d);
            peak_votes_q <= best_votes_d;
            peak_valid_q <= (best_votes_d >= thr_q) && (best_votes_d != 16'd0);
            over_count_q <= over_d;
          end
        end

        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          vld_p0_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.acc_raddr  = raddr_p0_q;
  assign bus.acc_we     = we_p1_q;
  assign bus.acc_waddr  = addr_p1_q;
  assign bus.acc_wdata  = 16'd0;
  assign bus.peak_r     = peak_r_q;
  assign bus.peak_angle = peak_angle_q;
  assign bus.peak_votes = peak_votes_q;
  assign bus.peak_valid = peak_valid_q;
  assign bus.over_count = over_count_q;

endmodule
